bcd_serial_adder: RTL and testbench
===================================

// Module: bcd_serial_adder
// PURPOSE
//  Multi-digit packed-BCD adder. It sequences the single-digit BCD add
//  (carry, x, y -> digit + carry) across DIGITS nibbles, least-significant
//  digit first, one digit per clock.
//  Sits above the digit-sum stage. It feeds that stage's operands, holds the
//  inter-digit carry in a register, and assembles the packed result.
//  The digit-add logic is internal; the block has no external digit-adder dependency.
// PARAMETERS
//  DIGITS  4  number of BCD digits per operand (>=1)
// PORTS
//  clk    in   1          rising-edge clock
//  rst    in   1          synchronous reset, active-high
//  start  in   1          request; sampled only when busy=0
//  a      in   4*DIGITS   operand A, packed BCD; a[3:0] is the LSD
//  b      in   4*DIGITS   operand B, packed BCD
//  cin    in   1          carry into the LSD
//  busy   out  1          high while digits are being processed
//  done   out  1          one-cycle pulse; result valid
//  sum    out  4*DIGITS   packed BCD result
//  cout   out  1          carry out of the MSD
//  invalid out 1          an operand nibble > 9 was detected at start
// BEHAVIOUR
//  Clock and reset:
//  - One clock. Reset is synchronous and active-high.
//  - rst=1 at an edge: state=IDLE; busy, done, cout, invalid = 0; sum = 0.
//  - Reset mid-operation aborts the add. No done pulse is produced.
//  States: IDLE, ADD, DONE.
//  IDLE/DONE + start=1:
//  - Latch a, b and cin; clear sum; load digit index = 0.
//  - If any nibble of a or b is > 9: go to DONE with invalid=1, sum=0, cout=0.
//  - Otherwise: clear invalid and go to ADD.
//  ADD (busy=1), per edge:
//  - t = a_i + b_i + c (5-bit).
//  - If t > 9: sum_i = (t+6)[3:0], c=1; else sum_i = t[3:0], c=0.
//  - Index increments. After digit DIGITS-1 is processed, cout=c and go to DONE.
//  DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
//  Latency (start sampled at edge E0):
//  - busy=1 from E0 until E(DIGITS).
//  - done=1 during the cycle after E(DIGITS).
//  - For the invalid path, done=1 during the cycle after E0.
//  Outputs:
//  - sum, cout and invalid hold their values until the next accepted start or reset.
//  - sum is partial, and not meaningful, while busy=1.
//  Start and reset interactions:
//  - start while busy=1 is ignored. Its operands are not captured.
//  - start in the DONE cycle is accepted (back-to-back operation).
//  - rst and start at the same edge: rst wins.
//  Carry rule: the carry between digits is always 0 or 1. With valid inputs no
//  digit exceeds 19, so a single +6 correction is sufficient.
// TESTING (DIGITS=4)
//  1. a=0x0999, b=0x0001, cin=0 -> sum=0x1000, cout=0, done 5 cycles after the start edge.
//  2. a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1. Also cin=1 with b=0 -> same result.
//  3. a=0x1234, b=0x5678, cin=1 -> sum=0x6913, cout=0, invalid=0.
//  4. a=0x00A0, b=0x0000 -> invalid=1, sum=0, cout=0, done in the cycle after the start edge.
//  5. Second start at cycle 2 of busy -> ignored; first result intact. rst at cycle 2 -> all outputs 0, no done pulse.
//  6. start held high through DONE -> second add begins immediately. Check 0x4999+0x5001 -> sum=0x0000, cout=1.

Source files
------------

// File: rtl/bcd_serial_adder_if.sv
// rtl/bcd_serial_adder_if.sv - operand/result bundle for the serial packed-BCD adder
//
// Purpose: groups the request (start, a, b, cin) and the response
// (busy, done, sum, cout, invalid) of bcd_serial_adder.
// Ports (signals):
//   start   request, sampled by the adder only while busy=0
//   a, b    packed BCD operands, [3:0] is the least-significant digit
//   cin     carry into the least-significant digit
//   busy    digits are being processed
//   done    one-cycle pulse, result valid
//   sum     packed BCD result
//   cout    carry out of the most-significant digit
//   invalid an operand nibble above 9 was seen when the request was taken
// Modports: master drives the request, slave is the adder.

interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
);

  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  invalid;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, invalid
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, invalid
  );

endinterface

// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - multi-digit packed-BCD adder, one digit per clock
//
// Purpose: adds two DIGITS-digit packed-BCD operands plus a carry-in,
// least-significant digit first, holding the inter-digit carry in a register
// and shifting each corrected digit into the top of the result.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high
//   bus   bcd_serial_adder_if.slave (start, a, b, cin -> busy, done, sum, cout, invalid)

module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  bcd_serial_adder_if.slave   bus
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry;
  logic [IW-1:0]   idx;
  logic            busy_q;
  logic            done_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            invalid_q;

  logic            bad_nibble;
  logic [4:0]      t;
  logic [4:0]      t_adj;
  logic [3:0]      digit;
  logic            digit_carry;
  logic [W-1:0]    sum_next;

  // Any operand nibble above 9 rejects the whole request.
  always_comb begin
    bad_nibble = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.a[4*i +: 4] > 4'd9 || bus.b[4*i +: 4] > 4'd9) begin
        bad_nibble = 1'b1;
      end
    end
  end

  // Operands are shifted right each step, so the current digit is always [3:0].
  // With valid digits t <= 19, so one +6 correction always suffices.
  always_comb begin
    t           = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, carry};
    t_adj       = t + 5'd6;
    digit       = t[3:0];
    digit_carry = 1'b0;
    if (t > 5'd9) begin
      digit       = t_adj[3:0];
      digit_carry = 1'b1;
    end
    // New digit enters at the top; after DIGITS steps the LSD reaches [3:0].
    sum_next = (sum_q >> 4) | (W'(digit) << (4 * (DIGITS - 1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
          if (bus.start) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            carry <= bus.cin;
            sum_q <= '0;
            idx   <= '0;
            if (bad_nibble) begin
              invalid_q <= 1'b1;
              cout_q    <= 1'b0;
              done_q    <= 1'b1;
              state     <= DONE;
            end else begin
              invalid_q <= 1'b0;
              cout_q    <= 1'b0;
              busy_q    <= 1'b1;
              state     <= ADD;
            end
          end
        end
        ADD: begin
          a_q   <= a_q >> 4;
          b_q   <= b_q >> 4;
          carry <= digit_carry;
          sum_q <= sum_next;
          if (idx == IW'(DIGITS - 1)) begin
            cout_q <= digit_carry;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sum     = sum_q;
  assign bus.cout    = cout_q;
  assign bus.invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb/tb_bcd_serial_adder.sv - scoreboard bench for bcd_serial_adder

module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_serial_adder_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         invalid;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Reference: decimal value of each operand, plain integer add, re-encode.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    exp_t e;
    int   av = 0;
    int   bv = 0;
    int   p  = 1;
    int   s;
    bit   bad = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) bad = 1;
      av += int'(a[4*i +: 4]) * p;
      bv += int'(b[4*i +: 4]) * p;
      p  *= 10;
    end
    e.sum = '0;
    e.due = 0;
    if (bad) begin
      e.cout    = 1'b0;
      e.invalid = 1'b1;
    end else begin
      s         = av + bv + int'(cin);
      e.cout    = (s >= p);
      e.invalid = 1'b0;
      s         = s % p;
      for (int i = 0; i < DIGITS; i++) begin
        e.sum[4*i +: 4] = 4'(s % 10);
        s = s / 10;
      end
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done at edge %0d: got done=1 want done=0", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sum", bus.sum, e.sum);
        check("cout", W'(bus.cout), W'(e.cout));
        check("invalid", W'(bus.invalid), W'(e.invalid));
        check("busy_at_done", W'(bus.busy), '0);
        check_int("done_edge", cyc, e.due);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: got busy=%b want 0", bus.busy);
    end
  endtask

  // Called at a negedge with the operands about to be accepted at the next edge.
  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    exp_t e;
    e     = model(a, b, cin);
    e.due = cyc + 1 + (e.invalid ? 0 : DIGITS);
    sb.push_back(e);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    wait_idle();
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    push_exp(a, b, cin);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           k;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", W'(bus.busy), '0);
    check("rst_done", W'(bus.done), '0);
    check("rst_sum", bus.sum, '0);
    check("rst_cout", W'(bus.cout), '0);
    check("rst_invalid", W'(bus.invalid), '0);
    rst = 1'b0;

    issue(16'h0999, 16'h0001, 1'b0);
    #1 check("busy_after_start", W'(bus.busy), W'(1'b1));
    issue(16'h9999, 16'h0001, 1'b0);
    issue(16'h9999, 16'h0000, 1'b1);
    issue(16'h1234, 16'h5678, 1'b1);
    drain();
    repeat (3) @(negedge clk);
    check("hold_sum", bus.sum, 16'h6913);
    check("hold_cout", W'(bus.cout), '0);
    issue(16'h00A0, 16'h0000, 1'b0);
    issue(16'h0000, 16'h0000, 1'b0);

    // Start during busy is ignored.
    issue(16'h2222, 16'h3333, 1'b0);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h7777;
    bus.b     = 16'h1111;
    @(posedge clk);
    #1 bus.start = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    check("ignored_start_sum", bus.sum, 16'h5555);

    // Reset mid-operation: outputs cleared, no done pulse follows.
    issue(16'h4321, 16'h1234, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    void'(sb.pop_back());
    check("midrst_busy", W'(bus.busy), '0);
    check("midrst_sum", bus.sum, '0);
    check("midrst_done", W'(bus.done), '0);
    repeat (8) @(negedge clk);
    check("post_rst_idle", W'(bus.busy), '0);

    // start held high through DONE: second add begins immediately.
    wait_idle();
    bus.start = 1'b1;
    bus.a     = 16'h1111;
    bus.b     = 16'h2222;
    bus.cin   = 1'b0;
    push_exp(16'h1111, 16'h2222, 1'b0);
    k = 0;
    @(negedge clk);
    while (bus.done !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("b2b_done_seen", W'(bus.done), W'(1'b1));
    bus.a = 16'h4999;
    bus.b = 16'h5001;
    push_exp(16'h4999, 16'h5001, 1'b0);
    @(posedge clk);
    #1;
    check("b2b_busy", W'(bus.busy), W'(1'b1));
    bus.start = 1'b0;
    drain();

    // Randomized traffic, with occasional illegal nibbles.
    for (int n = 0; n < 40; n++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      if ($urandom_range(0, 9) == 0) begin
        k = $urandom_range(0, DIGITS - 1);
        if ($urandom_range(0, 1) == 0) ra[4*k +: 4] = 4'($urandom_range(10, 15));
        else                           rb[4*k +: 4] = 4'($urandom_range(10, 15));
      end
      issue(ra, rb, 1'($urandom_range(0, 1)));
    end
    drain();
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
